// File: rtl/psram_clk_pkg.sv
// Shared definitions for the PSRAM clocking path: bring-up sequencer state encoding
// and the power-up wait length derived from the clock frequency.
package psram_clk_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK   = 3'd0,
        ST_LOCK_STABLE = 3'd1,
        ST_PWRUP_WAIT  = 3'd2,
        ST_CALIB       = 3'd3,
        ST_RUN         = 3'd4,
        ST_LOST        = 3'd5,
        ST_FAIL        = 3'd6
    } seq_state_e;

    function automatic int unsigned pwrup_cycles(input int unsigned clk_hz,
                                                 input int unsigned wait_us);
        return (clk_hz / 1_000_000) * wait_us;
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_lock_sync.sv
// Flop chain bringing the asynchronous PLL lock flag into the clkout domain.
module lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("lock_sync: SYNC_STAGES must be at least 2");
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Turns PLL lock into an ordered bring-up: lock qualify, core reset release,
// PSRAM power-up wait, init pulse, calibration wait; reports lock loss and calibration timeout.
module pll_lock_reset_seq
    import psram_clk_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ        = 81_000_000,
    parameter int unsigned PWRUP_US           = 150,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned CALIB_TIMEOUT      = 65536,
    parameter int          SYNC_STAGES        = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       pll_lock,
    input  logic       calib_done,
    output logic       core_resetn,
    output logic       psram_init,
    output logic       ready,
    output logic       lock_lost,
    output logic       calib_err,
    output logic [2:0] state_o
);

    localparam int unsigned PWRUP_CYC = pwrup_cycles(CLK_FREQ_HZ, PWRUP_US);
    localparam int unsigned CNT_MAX   = max3(LOCK_STABLE_CYCLES, PWRUP_CYC, CALIB_TIMEOUT);
    localparam int          CNT_W     = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PWRUP_LAST = CNT_W'(PWRUP_CYC - 1);
    localparam logic [CNT_W-1:0] CALIB_LAST = CNT_W'(CALIB_TIMEOUT - 1);

    if (PWRUP_CYC == 0) begin : g_bad_pwrup
        $error("pll_lock_reset_seq: power-up wait evaluates to zero cycles");
    end

    logic             lock_s;
    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lost_evt, tmo_evt;
    logic             core_resetn_q, psram_init_q, ready_q, lock_lost_q, calib_err_q;

    lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk    (clk),
        .resetn (resetn),
        .d_i    (pll_lock),
        .q_o    (lock_s)
    );

    // Lock loss is tested before any terminal count or calib_done so it always wins.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lost_evt = 1'b0;
        tmo_evt  = 1'b0;
        unique case (state_q)
            ST_WAIT_LOCK: begin
                cnt_d = '0;
                if (lock_s) state_d = ST_LOCK_STABLE;
            end
            ST_LOCK_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = ST_PWRUP_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PWRUP_WAIT: begin
                if (!lock_s) begin
                    state_d  = ST_LOST;
                    cnt_d    = '0;
                    lost_evt = 1'b1;
                end else if (cnt_q == PWRUP_LAST) begin
                    state_d = ST_CALIB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CALIB: begin
                if (!lock_s) begin
                    state_d  = ST_LOST;
                    cnt_d    = '0;
                    lost_evt = 1'b1;
                end else if (calib_done) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else if (cnt_q == CALIB_LAST) begin
                    state_d = ST_FAIL;
                    cnt_d   = '0;
                    tmo_evt = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_LOST;
                    lost_evt = 1'b1;
                end
            end
            ST_LOST: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
            ST_FAIL: begin
                if (!lock_s) lost_evt = 1'b1;
            end
            default: begin
                state_d = ST_WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_WAIT_LOCK;
            cnt_q         <= '0;
            core_resetn_q <= 1'b0;
            psram_init_q  <= 1'b0;
            ready_q       <= 1'b0;
            lock_lost_q   <= 1'b0;
            calib_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            core_resetn_q <= (state_d inside {ST_PWRUP_WAIT, ST_CALIB, ST_RUN});
            psram_init_q  <= (state_d == ST_CALIB) && (state_q != ST_CALIB);
            ready_q       <= (state_d == ST_RUN);
            lock_lost_q   <= lock_lost_q | lost_evt;
            calib_err_q   <= calib_err_q | tmo_evt;
        end
    end

    assign core_resetn = core_resetn_q;
    assign psram_init  = psram_init_q;
    assign ready       = ready_q;
    assign lock_lost   = lock_lost_q;
    assign calib_err   = calib_err_q;
    assign state_o     = state_q;

endmodule
